// File: rtl/spi_slave_pkg.sv
// spi_slave_pkg: shared widths, egress state type and shift helper for the SPI slave
package spi_slave_pkg;
    localparam int SPI_BYTE_W = 8;
    localparam int BIT_CNT_W  = 3;
    typedef enum logic {IDLE, SHIFT} egress_state_e;
    function automatic logic [SPI_BYTE_W-1:0] shift_next(input logic [SPI_BYTE_W-1:0] b, input bit msb_first);
        return msb_first ? b << 1 : b >> 1;
    endfunction
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-stage synchronizer for an asynchronous input with rise/fall pulses
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);
    logic [SYNC_STAGES-1:0] chain_q;
    logic                   prev_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            chain_q <= {SYNC_STAGES{RESET_VAL}};
            prev_q  <= RESET_VAL;
        end else begin
            chain_q <= {chain_q[SYNC_STAGES-2:0], async_i};
            prev_q  <= chain_q[SYNC_STAGES-1];
        end
    end
    assign sync_o = chain_q[SYNC_STAGES-1];
    assign rise_o = sync_o & ~prev_q;
    assign fall_o = ~sync_o & prev_q;
endmodule

// File: rtl/spi_slave_axis_egress_sync.sv
// spi_slave_axis_egress_sync: AXIS byte stream shifted out on SPI MISO, oversampled in the clk domain
// Optional SPI_SLAVE_AXIS_EGRESS_OE_EN adds spi_miso_oe and holds the last MISO bit while deselected.
module spi_slave_axis_egress_sync
    import spi_slave_pkg::*;
#(
    parameter int               MSB_FIRST   = 1,
    parameter logic [7:0]       IDLE_BYTE   = 8'h00,
    parameter int               SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_clk,
    input  logic       spi_csn,
    output logic       spi_miso,
`ifdef SPI_SLAVE_AXIS_EGRESS_OE_EN
    output logic       spi_miso_oe,
`endif
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    output logic       s_axis_tready,
    output logic       byte_sent,
    output logic       err_underrun
);
    logic clk_s, clk_rise, clk_fall, csn_s, csn_rise, csn_fall, unused_sync;
    egress_state_e         state_q;
    logic [BIT_CNT_W-1:0]  bit_cnt_q;
    logic [SPI_BYTE_W-1:0] shreg_q, hold_q, src_d;
    logic                  miso_q, hold_valid_q, sent_q, err_q;
`ifdef SPI_SLAVE_AXIS_EGRESS_OE_EN
    logic                  oe_q;
    assign spi_miso_oe = oe_q;
`endif
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_clk_sync (
        .clk(clk), .rst(rst), .async_i(spi_clk), .sync_o(clk_s), .rise_o(clk_rise), .fall_o(clk_fall)
    );
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_csn_sync (
        .clk(clk), .rst(rst), .async_i(spi_csn), .sync_o(csn_s), .rise_o(csn_rise), .fall_o(csn_fall)
    );
    assign unused_sync   = clk_s ^ clk_fall;
    // bit 0 of each byte pulls from the hold register, falling back to IDLE_BYTE on underrun
    assign src_d         = (bit_cnt_q == '0) ? (hold_valid_q ? hold_q : IDLE_BYTE) : shreg_q;
    assign s_axis_tready = ~rst & ~hold_valid_q;
    assign spi_miso      = miso_q;
    assign byte_sent     = sent_q;
    assign err_underrun  = err_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            miso_q       <= 1'b0;
            sent_q       <= 1'b0;
            err_q        <= 1'b0;
`ifdef SPI_SLAVE_AXIS_EGRESS_OE_EN
            oe_q         <= 1'b0;
`endif
        end else begin
            sent_q <= 1'b0;
`ifdef SPI_SLAVE_AXIS_EGRESS_OE_EN
            oe_q   <= ~csn_s;
`endif
            if (s_axis_tvalid && s_axis_tready) begin
                hold_q       <= s_axis_tdata;
                hold_valid_q <= 1'b1;
            end
            if (state_q == IDLE) begin
                bit_cnt_q <= '0;
                err_q     <= 1'b0;
`ifndef SPI_SLAVE_AXIS_EGRESS_OE_EN
                miso_q    <= 1'b0;
`endif
                if (csn_fall) state_q <= SHIFT;
            end else if (csn_rise) begin
                state_q   <= IDLE;
                bit_cnt_q <= '0;
                err_q     <= 1'b0;
`ifndef SPI_SLAVE_AXIS_EGRESS_OE_EN
                miso_q    <= 1'b0;
`endif
            end else if (clk_rise) begin
                if (bit_cnt_q == '0) begin
                    if (hold_valid_q) hold_valid_q <= 1'b0;
                    else err_q <= 1'b1;
                end
                miso_q    <= (MSB_FIRST != 0) ? src_d[SPI_BYTE_W-1] : src_d[0];
                shreg_q   <= shift_next(src_d, MSB_FIRST != 0);
                bit_cnt_q <= bit_cnt_q + 1'b1;
                sent_q    <= &bit_cnt_q;
            end
        end
    end
endmodule

// File: tb/tb_spi_slave_axis_egress_sync.sv
// tb_spi_slave_axis_egress_sync: randomized SPI master + AXIS feeder against a byte-level model
// Two DUTs share stimulus: MSB-first with IDLE 8'h00, LSB-first with IDLE 8'hC3.
module tb_spi_slave_axis_egress_sync;
    localparam int HALF = 8;
    logic clk = 0, rst = 1, spi_clk = 0, spi_csn = 1, tvalid = 0;
    logic [7:0] tdata = 0;
    logic miso0, miso1, ready0, ready1, sent0, sent1, err0, err1;
`ifdef SPI_SLAVE_AXIS_EGRESS_OE_EN
    logic oe0, oe1;
`endif
    int checks = 0, errors = 0, sent_cnt0 = 0, sent_cnt1 = 0;
    logic [7:0] model_q[$], feed_q[$];
    logic rx0[$], rx1[$];
    bit window = 0, hs = 0;

    always #5 clk = ~clk;

    spi_slave_axis_egress_sync #(.MSB_FIRST(1), .IDLE_BYTE(8'h00), .SYNC_STAGES(2)) dut0 (
        .clk(clk), .rst(rst), .spi_clk(spi_clk), .spi_csn(spi_csn), .spi_miso(miso0),
`ifdef SPI_SLAVE_AXIS_EGRESS_OE_EN
        .spi_miso_oe(oe0),
`endif
        .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tready(ready0),
        .byte_sent(sent0), .err_underrun(err0));
    spi_slave_axis_egress_sync #(.MSB_FIRST(0), .IDLE_BYTE(8'hC3), .SYNC_STAGES(2)) dut1 (
        .clk(clk), .rst(rst), .spi_clk(spi_clk), .spi_csn(spi_csn), .spi_miso(miso1),
`ifdef SPI_SLAVE_AXIS_EGRESS_OE_EN
        .spi_miso_oe(oe1),
`endif
        .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tready(ready1),
        .byte_sent(sent1), .err_underrun(err1));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [7:0] rx_byte(input int which, input int idx);
        logic [7:0] v = '0;
        for (int i = 0; i < 8; i++) v = {v[6:0], which != 0 ? rx1[idx*8+i] : rx0[idx*8+i]};
        return v;
    endfunction

    // accepted beats become the model's hold contents; byte_sent pulses are counted
    always @(posedge clk) begin
        hs = tvalid && ready0 && !rst;
        if (hs) model_q.push_back(tdata);
        if (sent0) sent_cnt0++;
        if (sent1) sent_cnt1++;
    end

    // new beats start only while the hold is known full or away from SPI rising edges
    initial forever begin
        @(negedge clk);
        if (tvalid && hs) tvalid = 0;
        if (!tvalid && !rst && feed_q.size() > 0 && (window || model_q.size() > 0)) begin
            tdata  = feed_q.pop_front();
            tvalid = 1;
        end
    end

    task automatic xfer(input int nbytes, input int abort_bits);
        logic [7:0] cur0 = '0, cur1 = '0;
        logic exp_err = 0;
        int base0 = sent_cnt0, base1 = sent_cnt1;
        int total = abort_bits >= 0 ? abort_bits : nbytes * 8;
        rx0.delete(); rx1.delete();
        window = 0;
        wait_clk(2);
        spi_csn = 0;
        wait_clk(5);
        for (int b = 0; b < total; b++) begin
            int bi = b % 8;
            spi_clk = 1;
            if (bi == 0) begin
                if (model_q.size() > 0) begin
                    cur0 = model_q.pop_front();
                    cur1 = cur0;
                end else begin
                    cur0 = 8'h00; cur1 = 8'hC3; exp_err = 1;
                end
            end
            wait_clk(HALF);
            spi_clk = 0;
            window  = 1;
            chk("miso_msb_first", miso0, cur0[7-bi]);
            chk("miso_lsb_first", miso1, cur1[bi]);
            chk("err_underrun0", err0, exp_err);
            chk("err_underrun1", err1, exp_err);
            rx0.push_back(miso0);
            rx1.push_back(miso1);
            if (bi == 7) begin
                chk("byte_sent0", sent_cnt0 - base0, b / 8 + 1);
                chk("byte_sent1", sent_cnt1 - base1, b / 8 + 1);
            end
            wait_clk(3);
            window = 0;
            wait_clk(HALF - 3);
        end
        spi_csn = 1;
        wait_clk(6);
        chk("err_cleared0", err0, 0);
        chk("err_cleared1", err1, 0);
        chk("sent_total0", sent_cnt0 - base0, total / 8);
        chk("sent_total1", sent_cnt1 - base1, total / 8);
`ifdef SPI_SLAVE_AXIS_EGRESS_OE_EN
        chk("oe_idle", oe0, 0);
`else
        chk("miso_idle", miso0, 0);
`endif
        window = 1;
    endtask

    task automatic push(input logic [7:0] d);
        feed_q.push_back(d);
    endtask

    initial begin
        wait_clk(3);
        chk("rst_miso", miso0, 0);
        chk("rst_tready", ready0, 0);
        chk("rst_byte_sent", sent0, 0);
        chk("rst_err", err0, 0);
        rst = 0;
        wait_clk(1);
        chk("post_rst_tready0", ready0, 1);
        chk("post_rst_tready1", ready1, 1);
        window = 1;

        push(8'hA5); wait_clk(4);
        xfer(1, -1);
        chk("a5_msb", rx_byte(0, 0), 8'hA5);
        chk("a5_lsb_order", rx_byte(1, 0), 8'hA5);

        push(8'h01); wait_clk(4);
        xfer(1, -1);
        chk("h01_lsb_order", rx_byte(1, 0), 8'h80);
        chk("h01_msb", rx_byte(0, 0), 8'h01);

        xfer(1, -1);
        chk("underrun_idle0", rx_byte(0, 0), 8'h00);
        chk("underrun_idle1", rx_byte(1, 0), 8'hC3);

        push(8'h12); push(8'h34); push(8'h56); wait_clk(4);
        xfer(3, -1);
        chk("stream_b0", rx_byte(0, 0), 8'h12);
        chk("stream_b1", rx_byte(0, 1), 8'h34);
        chk("stream_b2", rx_byte(0, 2), 8'h56);

        push(8'hFF); wait_clk(4);
        xfer(1, 3);
        push(8'h0F); wait_clk(4);
        xfer(1, -1);
        chk("after_abort", rx_byte(0, 0), 8'h0F);

        push(8'hAB); wait_clk(4);
        window = 0;
        spi_csn = 0; wait_clk(5);
        spi_clk = 1;
        void'(model_q.pop_front());
        push(8'hCD);
        wait_clk(HALF); spi_clk = 0; window = 1; wait_clk(4); window = 0; wait_clk(HALF - 4);
        spi_clk = 1; wait_clk(4);
        rst = 1; spi_csn = 1; spi_clk = 0; tvalid = 0;
        feed_q.delete();
        wait_clk(1);
        chk("midrst_miso", miso0, 0);
        chk("midrst_tready", ready0, 0);
        chk("midrst_err", err0, 0);
        wait_clk(2);
        model_q.delete();
        rst = 0;
        wait_clk(1);
        chk("midrst_tready_after", ready0, 1);
        xfer(1, -1);
        chk("midrst_idle_byte", rx_byte(0, 0), 8'h00);

        for (int t = 0; t < 40; t++) begin
            int n = $urandom_range(1, 3);
            int p = $urandom_range(0, n + 1);
            for (int k = 0; k < p && feed_q.size() < 4; k++) push(8'($urandom));
            window = 1;
            wait_clk(4);
            xfer(n, ($urandom % 5 == 0) ? $urandom_range(1, n * 8 - 1) : -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
